// File: rtl/sub86_memctl_if.sv
// Memory-side bus of sub86_memctl: one 16-bit transaction per MREQ/MACK handshake.
// Lane 0 (MBE[0], data[7:0]) is the even byte of the halfword at MADDR.
interface sub86_memctl_if;
    logic        MREQ;
    logic        MWE;
    logic [30:0] MADDR;
    logic [1:0]  MBE;
    logic [15:0] MWDATA;
    logic [15:0] MRDATA;
    logic        MACK;

    modport master (
        output MREQ, MWE, MADDR, MBE, MWDATA,
        input  MRDATA, MACK
    );

    modport slave (
        input  MREQ, MWE, MADDR, MBE, MWDATA,
        output MRDATA, MACK
    );
endinterface

// File: rtl/sub86_memctl.sv
// Serialises one CPU step (posted write, instruction fetch, data read) onto a 16-bit memory bus.
// The CPU is stalled through CE, which is high only in the final DONE state.
module sub86_memctl #(
    parameter logic [15:0] RESET_ID = 16'h9090
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           IA,
    output logic [15:0]           ID,
    input  logic [31:0]           A,
    input  logic [31:0]           Q,
    output logic [31:0]           D,
    input  logic                  WEN,
    input  logic                  RD,
    input  logic [1:0]            BEN,
    output logic                  CE,
    sub86_memctl_if.master        mem
);

    localparam logic [1:0] BenDword = 2'b01;

    typedef enum logic [2:0] {
        StWr0, StWr1, StIf0, StIf1, StDec, StRd0, StRd1, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] id_q, id_d;
    logic [31:0] d_q, d_d;
    logic [31:0] wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [1:0]  wb_ben_q, wb_ben_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [1:0]  rd_ben_q, rd_ben_d;

    logic        bus_req, bus_we, ack;
    logic [30:0] bus_addr;
    logic [1:0]  bus_be;
    logic [15:0] bus_wdata;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIf0;
            id_q      <= RESET_ID;
            d_q       <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            wb_ben_q  <= '0;
            rd_addr_q <= '0;
            rd_ben_q  <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            d_q       <= d_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            wb_ben_q  <= wb_ben_d;
            rd_addr_q <= rd_addr_d;
            rd_ben_q  <= rd_ben_d;
        end
    end

    // Bus outputs decode from the state register; IA is used live while fetching.
    always_comb begin
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_be    = '0;
        bus_wdata = '0;
        unique case (state_q)
            StWr0: begin
                bus_req  = 1'b1;
                bus_we   = 1'b1;
                bus_addr = wb_addr_q[31:1];
                if (wb_ben_q[0]) begin
                    bus_be    = 2'b11;
                    bus_wdata = wb_data_q[15:0];
                end else begin
                    bus_be    = wb_addr_q[0] ? 2'b10 : 2'b01;
                    bus_wdata = {2{wb_data_q[7:0]}};
                end
            end
            StWr1: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = wb_addr_q[31:1] + 31'd1;
                bus_be    = 2'b11;
                bus_wdata = wb_data_q[31:16];
            end
            StIf0: begin
                bus_req  = 1'b1;
                bus_addr = IA[31:1];
                bus_be   = 2'b11;
            end
            StIf1: begin
                bus_req  = 1'b1;
                bus_addr = IA[31:1] + 31'd1;
                bus_be   = 2'b11;
            end
            StRd0: begin
                bus_req  = 1'b1;
                bus_addr = rd_addr_q[31:1];
                bus_be   = 2'b11;
            end
            StRd1: begin
                bus_req  = 1'b1;
                bus_addr = rd_addr_q[31:1] + 31'd1;
                bus_be   = 2'b11;
            end
            default: ;
        endcase
        if (RST) begin
            bus_req   = 1'b0;
            bus_we    = 1'b0;
            bus_addr  = '0;
            bus_be    = '0;
            bus_wdata = '0;
        end
    end

    assign mem.MREQ   = bus_req;
    assign mem.MWE    = bus_we;
    assign mem.MADDR  = bus_addr;
    assign mem.MBE    = bus_be;
    assign mem.MWDATA = bus_wdata;
    assign ack        = bus_req & mem.MACK;

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        d_d       = d_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        wb_ben_d  = wb_ben_q;
        rd_addr_d = rd_addr_q;
        rd_ben_d  = rd_ben_q;
        unique case (state_q)
            StWr0: if (ack) state_d = (wb_ben_q == BenDword) ? StWr1 : StIf0;
            StWr1: if (ack) state_d = StIf0;
            StIf0: begin
                if (ack) begin
                    if (IA[0]) begin
                        id_d[15:8] = mem.MRDATA[15:8];
                        state_d    = StIf1;
                    end else begin
                        id_d    = {mem.MRDATA[7:0], mem.MRDATA[15:8]};
                        state_d = StDec;
                    end
                end
            end
            StIf1: begin
                if (ack) begin
                    id_d[7:0] = mem.MRDATA[7:0];
                    state_d   = StDec;
                end
            end
            StDec: begin
                rd_addr_d = A;
                rd_ben_d  = BEN;
                state_d   = RD ? StRd0 : StDone;
            end
            StRd0: begin
                if (ack) begin
                    state_d = StDone;
                    case (rd_ben_q)
                        2'b01: begin
                            d_d[15:0] = mem.MRDATA;
                            state_d   = StRd1;
                        end
                        2'b11:   d_d = {16'h0, mem.MRDATA};
                        default: d_d = {24'h0, rd_addr_q[0] ? mem.MRDATA[15:8] : mem.MRDATA[7:0]};
                    endcase
                end
            end
            StRd1: begin
                if (ack) begin
                    d_d[31:16] = mem.MRDATA;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (!WEN) begin
                    wb_addr_d = A;
                    wb_data_d = Q;
                    wb_ben_d  = BEN;
                    state_d   = StWr0;
                end else begin
                    state_d = StIf0;
                end
            end
            default: state_d = StIf0;
        endcase
    end

    assign ID = id_q;
    assign D  = d_q;
    assign CE = (state_q == StDone);

endmodule

// File: tb/tb_sub86_memctl.sv
// Randomised bench for sub86_memctl: byte-addressed memory slave plus a step-level CPU model.
// Expected ID/D/memory come from byte arithmetic on a reference memory, not from bus states.
module tb_sub86_memctl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] IA, A, Q, D;
    logic [15:0] ID;
    logic        WEN, RD, CE;
    logic [1:0]  BEN;

    sub86_memctl_if bus ();

    sub86_memctl #(.RESET_ID(16'h9090)) dut (
        .CLK (CLK),
        .RST (RST),
        .IA  (IA),
        .ID  (ID),
        .A   (A),
        .Q   (Q),
        .D   (D),
        .WEN (WEN),
        .RD  (RD),
        .BEN (BEN),
        .CE  (CE),
        .mem (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory slave ----------------
    logic [7:0] smem    [0:131071];
    logic [7:0] ref_mem [0:131071];

    typedef struct {
        logic [30:0] addr;
        logic        we;
        logic [15:0] wdata;
    } txn_t;
    txn_t log_q[$];

    bit          rand_w = 1'b0;
    int          wait_max = 0, wait_cnt = 0, wait_tgt = 0;
    bit          hold = 1'b0;
    logic [30:0] snap_addr;
    logic [1:0]  snap_be;
    logic [15:0] snap_wdata;
    logic        snap_we;

    assign bus.MRDATA = {smem[{bus.MADDR[15:0], 1'b1}], smem[{bus.MADDR[15:0], 1'b0}]};

    task automatic set_waits(input int w, input bit rnd);
        rand_w   = rnd;
        wait_max = w;
        wait_cnt = 0;
        wait_tgt = rnd ? int'($urandom_range(0, 2)) : w;
    endtask

    always @(negedge CLK) begin
        if (rand_w)
            bus.MACK = bus.MREQ ? (wait_cnt >= wait_tgt) : 1'($urandom_range(0, 1));
        else if (wait_max == 0)
            bus.MACK = 1'b1;
        else
            bus.MACK = bus.MREQ && (wait_cnt >= wait_tgt);
    end

    always @(posedge CLK) begin
        if (!RST) begin
            if (hold) begin
                check_eq("hold_req", bus.MREQ, 1'b1);
                check_eq("hold_addr", bus.MADDR, snap_addr);
                check_eq("hold_be", bus.MBE, snap_be);
                check_eq("hold_wdata", bus.MWDATA, snap_wdata);
                check_eq("hold_we", bus.MWE, snap_we);
            end
            hold = 1'b0;
            if (bus.MREQ && bus.MACK) begin
                log_q.push_back('{addr: bus.MADDR, we: bus.MWE, wdata: bus.MWDATA});
                if (bus.MWE && bus.MBE[0]) smem[{bus.MADDR[15:0], 1'b0}] = bus.MWDATA[7:0];
                if (bus.MWE && bus.MBE[1]) smem[{bus.MADDR[15:0], 1'b1}] = bus.MWDATA[15:8];
                wait_cnt = 0;
                wait_tgt = rand_w ? int'($urandom_range(0, 2)) : wait_max;
            end else if (bus.MREQ) begin
                wait_cnt++;
                hold       = 1'b1;
                snap_addr  = bus.MADDR;
                snap_be    = bus.MBE;
                snap_wdata = bus.MWDATA;
                snap_we    = bus.MWE;
            end
        end
    end

    always @(posedge RST) begin
        hold     = 1'b0;
        wait_cnt = 0;
        wait_tgt = rand_w ? int'($urandom_range(0, 2)) : wait_max;
    end

    // ---------------- reference model ----------------
    bit          pend_v = 1'b0;
    logic [31:0] pend_a, pend_q;
    logic [1:0]  pend_ben;
    logic [31:0] exp_d = '0;

    function automatic int nbytes(input logic [1:0] ben);
        return (ben == 2'b01) ? 4 : (ben == 2'b11) ? 2 : 1;
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] a, input logic [1:0] ben);
        return (nbytes(ben) > 1) ? {a[31:1], 1'b0} : a;
    endfunction

    function automatic logic [7:0] rb(input logic [31:0] addr);
        return ref_mem[addr[16:0]];
    endfunction

    // One CPU step: drive inputs, wait for CE, compare, then take the DONE edge.
    // w >= 0 is a fixed per-transaction wait count and enables the cycle-count check.
    task automatic run_step(input logic [31:0] ia, input logic [31:0] a, input logic [31:0] q,
                            input logic rd, input logic wen, input logic [1:0] ben, input int w);
        logic [31:0] base, exp_dn;
        logic [15:0] exp_id;
        int          ntr, cycles;
        bit          ce_seen;
        ntr = (ia[0] ? 2 : 1) + (rd ? (ben == 2'b01 ? 2 : 1) : 0);
        if (pend_v) begin
            ntr += (pend_ben == 2'b01) ? 2 : 1;
            base = base_of(pend_a, pend_ben);
            for (int k = 0; k < nbytes(pend_ben); k++) begin
                logic [31:0] ba;
                ba = base + 32'(k);
                ref_mem[ba[16:0]] = pend_q[8*k +: 8];
            end
        end
        exp_id = {rb(ia), rb(ia + 32'd1)};
        if (rd) begin
            base   = base_of(a, ben);
            exp_dn = {rb(base + 32'd3), rb(base + 32'd2), rb(base + 32'd1), rb(base)};
            if (ben == 2'b11)      exp_d = {16'h0, exp_dn[15:0]};
            else if (ben == 2'b01) exp_d = exp_dn;
            else                   exp_d = {24'h0, rb(a)};
        end
        log_q.delete();
        IA = ia; A = a; Q = q; RD = rd; WEN = wen; BEN = ben;
        cycles  = 0;
        ce_seen = 1'b0;
        while (!ce_seen && cycles < 200) begin
            @(negedge CLK);
            cycles++;
            ce_seen = CE;
        end
        check_eq("ce_seen", ce_seen, 1'b1);
        if (!ce_seen) begin
            $display("FAIL ce_timeout: got no CE expected CE within 200 cycles");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $fatal(1, "stalled");
        end
        check_eq("step_id", ID, exp_id);
        check_eq("step_d", D, exp_d);
        if (w >= 0) check_eq("step_cycles", cycles, ntr * (w + 1) + 2);
        @(posedge CLK);
        #1;
        WEN      = 1'b1;
        pend_v   = !wen;
        pend_a   = a;
        pend_q   = q;
        pend_ben = ben;
    endtask

    task automatic reset_model();
        pend_v = 1'b0;
        exp_d  = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        for (int i = 0; i < 131072; i++) begin
            smem[i]    = 8'($urandom);
            ref_mem[i] = smem[i];
        end
        smem[17'h1000] = 8'hEB; ref_mem[17'h1000] = 8'hEB;
        smem[17'h1001] = 8'h05; ref_mem[17'h1001] = 8'h05;
        for (int i = 0; i < 4; i++) begin
            smem[17'h2000 + 17'(i)]    = 8'(8'h11 * (i + 1));
            ref_mem[17'h2000 + 17'(i)] = 8'(8'h11 * (i + 1));
        end
        set_waits(0, 1'b0);
        RST = 1'b1; IA = 32'h0000_1000; A = '0; Q = '0; WEN = 1'b1; RD = 1'b0; BEN = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_id", ID, 16'h9090);
        check_eq("rst_d", D, 32'h0);
        check_eq("rst_ce", CE, 1'b0);
        check_eq("rst_mreq", bus.MREQ, 1'b0);
        check_eq("rst_mwe", bus.MWE, 1'b0);
        check_eq("rst_mbe", bus.MBE, 2'b00);
        check_eq("rst_maddr", bus.MADDR, 31'h0);
        check_eq("rst_mwdata", bus.MWDATA, 16'h0);
        RST = 1'b0;
        #1;
        check_eq("first_fetch_addr", bus.MADDR, 31'h800);
        check_eq("first_fetch_req", bus.MREQ, 1'b1);

        // Zero-wait even fetch, repeated to show the 3-cycle CE period.
        run_step(32'h1000, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 0);
        check_eq("fetch_id", ID, 16'hEB05);
        run_step(32'h1000, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 0);

        // Odd fetch with two wait cycles per transaction.
        set_waits(2, 1'b0);
        run_step(32'h1003, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 2);
        check_eq("odd_ntxn", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check_eq("odd_addr0", log_q[0].addr, 31'h801);
            check_eq("odd_addr1", log_q[1].addr, 31'h802);
        end
        set_waits(0, 1'b0);

        run_step(32'h1000, 32'h2000, 32'h0, 1'b1, 1'b1, 2'b01, 0);
        check_eq("dword_rd", D, 32'h4433_2211);

        // Posted byte write goes out right after the DONE edge.
        run_step(32'h1000, 32'h2001, 32'hAB, 1'b0, 1'b0, 2'b00, 0);
        check_eq("pw_mreq", bus.MREQ, 1'b1);
        check_eq("pw_mwe", bus.MWE, 1'b1);
        check_eq("pw_maddr", bus.MADDR, 31'h1000);
        check_eq("pw_mbe", bus.MBE, 2'b10);
        check_eq("pw_mwdata", bus.MWDATA, 16'hABAB);

        run_step(32'h1002, 32'h161F8, 32'h1234_5678, 1'b0, 1'b0, 2'b01, 0);
        check_eq("pw_mem", smem[17'h2001], 8'hAB);
        run_step(32'h1004, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 0);
        check_eq("push_ntxn", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check_eq("push_a0", log_q[0].addr, 31'hB0FC);
            check_eq("push_d0", log_q[0].wdata, 16'h5678);
            check_eq("push_w0", log_q[0].we, 1'b1);
            check_eq("push_a1", log_q[1].addr, 31'hB0FD);
            check_eq("push_d1", log_q[1].wdata, 16'h1234);
            check_eq("push_a2", log_q[2].addr, 31'h802);
            check_eq("push_w2", log_q[2].we, 1'b0);
        end

        // Reset while the second half of a dword read is waiting.
        set_waits(3, 1'b0);
        IA = 32'h1006; A = 32'h2000; RD = 1'b1; BEN = 2'b01; WEN = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge CLK);
            found = bus.MREQ && !bus.MWE && (bus.MADDR == 31'h1001);
        end
        check_eq("rd1_reached", found, 1'b1);
        #1 RST = 1'b1;
        #1;
        reset_model();
        check_eq("rst_rd1_mreq", bus.MREQ, 1'b0);
        check_eq("rst_rd1_id", ID, 16'h9090);
        check_eq("rst_rd1_d", D, 32'h0);
        @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        check_eq("restart_addr", bus.MADDR, 31'h803);
        check_eq("restart_mwe", bus.MWE, 1'b0);
        run_step(32'h1006, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 3);

        // Reset during a posted write must drop it.
        set_waits(0, 1'b0);
        run_step(32'h1000, 32'h3000, $urandom, 1'b0, 1'b0, 2'b01, 0);
        set_waits(3, 1'b0);
        check_eq("wr_pending", bus.MWE, 1'b1);
        RST = 1'b1;
        #1;
        reset_model();
        check_eq("rst_wr_mreq", bus.MREQ, 1'b0);
        @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        check_eq("after_wr_rst_addr", bus.MADDR, 31'h800);
        check_eq("after_wr_rst_mwe", bus.MWE, 1'b0);
        run_step(32'h1000, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 3);
        for (int i = 0; i < 4; i++)
            check_eq("discard_mem", smem[17'h3000 + 17'(i)], ref_mem[17'h3000 + 17'(i)]);

        // Random steps: zero-wait with cycle counts, then random waits and stray MACK.
        set_waits(0, 1'b0);
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ia, a;
            if (n == 150) set_waits(0, 1'b1);
            ia = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFD + $urandom_range(0, 2)
                                              : 32'h1000 + $urandom_range(0, 63);
            a  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFD + $urandom_range(0, 2)
                                              : 32'h1000 + $urandom_range(0, 127);
            run_step(ia, a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), (n < 150) ? 0 : -1);
        end
        set_waits(0, 1'b0);
        run_step(32'h1000, 32'h0, 32'h0, 1'b0, 1'b1, 2'b00, 0);
        for (int i = 0; i < 131072; i++) begin
            if (i < 17'h1200 || i >= 17'h1FFF0)
                check_eq("final_mem", smem[i], ref_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
